seq_det_ctrl: RTL and testbench

Programmable serial sequence-detection controller. Holds a run-time configured pattern of 1..MAX_LEN bits, arms on command, and compares a qualified serial bit stream against that pattern. It counts matches and stops after a target count. Software or a parent FSM configures, starts and aborts it; downstream logic consumes the match pulse and the done/busy status.

---
 rtl/seq_det_ctrl.sv | 178 +++++++++++++++++
 tb/tb_seq_det_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - programmable serial sequence detector with match counting
// Optional run timeout enabled by defining SEQ_DET_TIMEOUT_EN.
`timescale 1ns/1ps
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               cfg_overlap,
`ifdef SEQ_DET_TIMEOUT_EN
  input  logic [TO_W-1:0]    cfg_timeout,
  output logic               timeout,
`endif
  input  logic               start,
  input  logic               abort,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic [CNT_W-1:0]   tgt_r;
  logic               ovl_r;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_nxt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               hit;
  logic               tgt_hit;
  logic               len_ok;
  logic               start_ok;
  logic               to_hit;

`ifdef SEQ_DET_TIMEOUT_EN
  logic [TO_W-1:0]    to_r;
  logic [TO_W-1:0]    to_cnt;
  logic [TO_W-1:0]    to_inc;
`endif

  always_comb begin
    hist_nxt = {hist[MAX_LEN-2:0], bit_in};
    fill_nxt = (fill >= len_r) ? len_r : fill + 1'b1;
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_r));
    end
    // Only the low len bits of history take part in the comparison.
    hit      = (fill_nxt == len_r) && (((hist_nxt ^ pat_r) & mask) == '0);
    cnt_inc  = (&match_count) ? match_count : match_count + 1'b1;
    tgt_hit  = (tgt_r != '0) && (cnt_inc == tgt_r);
    len_ok   = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    start_ok = start && ((state != IDLE) || !cfg_err);
`ifdef SEQ_DET_TIMEOUT_EN
    to_inc   = to_cnt + 1'b1;
    to_hit   = (to_r != '0) && (to_inc == to_r) && !hit;
`else
    to_hit   = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pat_r       <= '0;
      len_r       <= LEN_W'(1);
      tgt_r       <= '0;
      ovl_r       <= 1'b0;
      hist        <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
      to_r        <= '0;
      to_cnt      <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      match <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
        timeout <= 1'b0;
`endif
      end else if (start_ok) begin
        state       <= RUN;
        busy        <= 1'b1;
        done        <= 1'b0;
        match_count <= '0;
        hist        <= '0;
        fill        <= '0;
`ifdef SEQ_DET_TIMEOUT_EN
        to_cnt      <= '0;
        timeout     <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (cfg_we) begin
              if (len_ok) begin
                pat_r   <= cfg_pattern;
                len_r   <= cfg_len;
                tgt_r   <= cfg_target;
                ovl_r   <= cfg_overlap;
`ifdef SEQ_DET_TIMEOUT_EN
                to_r    <= cfg_timeout;
`endif
                cfg_err <= 1'b0;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          RUN: begin
            if (bit_valid) begin
              hist <= hist_nxt;
              fill <= fill_nxt;
`ifdef SEQ_DET_TIMEOUT_EN
              to_cnt <= to_inc;
`endif
              if (hit) begin
                match       <= 1'b1;
                match_count <= cnt_inc;
`ifdef SEQ_DET_TIMEOUT_EN
                to_cnt      <= '0;
`endif
                if (!ovl_r) fill <= '0;
                if (tgt_hit) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end else if (to_hit) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
`ifdef SEQ_DET_TIMEOUT_EN
                timeout <= 1'b1;
`endif
              end
            end
          end
          DONE: ;
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - directed bench for seq_det_ctrl with a match scoreboard
`timescale 1ns/1ps
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_target;
  logic       cfg_overlap;
  logic       start;
  logic       abort;
  logic       bit_valid;
  logic       bit_in;
  logic       match;
  logic [7:0] match_count;
  logic       busy;
  logic       done;
  logic       cfg_err;
`ifdef SEQ_DET_TIMEOUT_EN
  logic [15:0] cfg_timeout;
  logic        timeout;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_q[$];

  seq_det_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_target  (cfg_target),
    .cfg_overlap (cfg_overlap),
`ifdef SEQ_DET_TIMEOUT_EN
    .cfg_timeout (cfg_timeout),
    .timeout     (timeout),
`endif
    .start       (start),
    .abort       (abort),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .match       (match),
    .match_count (match_count),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Each match pulse must correspond to the oldest outstanding expected cycle.
  always @(negedge clk) begin
    if (match === 1'b1) begin
      if (exp_q.size() == 0) check("match_unexpected", match, 0);
      else check("match_cycle", cyc, exp_q.pop_front());
    end
  end

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t, input logic o);
    cfg_pattern = p; cfg_len = l; cfg_target = t; cfg_overlap = o; cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic step(input logic v, input logic b, input logic m);
    bit_valid = v; bit_in = b;
    if (m) exp_q.push_back(cyc + 1);
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 0; cfg_pattern = 0; cfg_len = 1; cfg_target = 0; cfg_overlap = 0;
    start = 0; abort = 0; bit_valid = 0; bit_in = 0;
`ifdef SEQ_DET_TIMEOUT_EN
    cfg_timeout = 0;
`endif
    repeat (2) @(negedge clk);
    check("rst_match", match, 0);
    check("rst_count", match_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic 011, target 2, no overlap
    cfg(8'b011, 3, 2, 0);
    pulse_start();
    check("t1_busy_run", busy, 1);
    step(1,0,0); step(1,1,0); step(1,1,1); step(1,0,0); step(1,1,0); step(1,1,1);
    check("t1_count", match_count, 2);
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);
    pulse_abort();
    check("t1_abort_done", done, 0);

    // Overlap on: 10101 -> two matches
    cfg(8'b101, 3, 0, 1);
    pulse_start();
    step(1,1,0); step(1,0,0); step(1,1,1); step(1,0,0); step(1,1,1);
    check("t2_ovl_count", match_count, 2);
    check("t2_ovl_busy", busy, 1);
    pulse_abort();

    // Overlap off: 10101 -> one match
    cfg(8'b101, 3, 0, 0);
    pulse_start();
    step(1,1,0); step(1,0,0); step(1,1,1); step(1,0,0); step(1,1,0);
    check("t2_novl_count", match_count, 1);
    check("t2_novl_busy", busy, 1);
    pulse_abort();

    // Valid gaps with junk bit_in between valid bits
    cfg(8'b011, 3, 2, 0);
    pulse_start();
    begin
      logic [5:0] bits;
      logic [5:0] hits;
      bits = 6'b011011;
      hits = 6'b001001;
      for (int i = 5; i >= 0; i--) begin
        step(1, bits[i], hits[i]);
        for (int k = 0; k < 3; k++) step(0, k[0], 0);
      end
    end
    check("t3_count", match_count, 2);
    check("t3_done", done, 1);
    pulse_start();
    check("t3_restart_busy", busy, 1);
    check("t3_restart_count", match_count, 0);
    pulse_abort();

    // Config errors
    cfg(8'b011, 0, 0, 0);
    check("t4_len0_err", cfg_err, 1);
    pulse_start();
    check("t4_len0_busy", busy, 0);
    cfg(8'b011, 9, 0, 0);
    check("t4_len9_err", cfg_err, 1);
    cfg(8'b011, 3, 0, 0);
    check("t4_legal_err", cfg_err, 0);
    pulse_start();
    check("t4_legal_busy", busy, 1);

    // cfg_we in RUN is ignored, start+abort together goes to IDLE
    cfg(8'b011, 0, 0, 0);
    check("t5_run_cfg_err", cfg_err, 0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("t5_prio_busy", busy, 0);
    check("t5_prio_done", done, 0);

    // Saturating target of all-ones with a 1-bit pattern
    cfg(8'h01, 1, 8'hFF, 1);
    pulse_start();
    for (int i = 0; i < 255; i++) step(1, 1, 1);
    check("t6_sat_count", match_count, 255);
    check("t6_sat_done", done, 1);
    pulse_abort();

    // Reset mid-stream after two matches
    cfg(8'b011, 3, 0, 1);
    pulse_start();
    step(1,0,0); step(1,1,0); step(1,1,1); step(1,0,0); step(1,1,0); step(1,1,1);
    check("t7_pre_count", match_count, 2);
    #2 reset = 1'b1;
    #1;
    check("t7_rst_count", match_count, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_match", match, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Default config after reset: len 1, pattern 0
    pulse_start();
    step(1,0,1); step(1,1,0);
    check("t8_default_count", match_count, 1);
    pulse_abort();

`ifdef SEQ_DET_TIMEOUT_EN
    cfg_timeout = 16'd4;
    cfg(8'b011, 3, 0, 0);
    pulse_start();
    step(1,1,0); step(1,1,0); step(1,1,0); step(1,1,0);
    check("t9_timeout", timeout, 1);
    check("t9_done", done, 1);
    check("t9_count", match_count, 0);
    pulse_abort();
    check("t9_abort_timeout", timeout, 0);
`endif

    repeat (3) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
